// File: rtl/coeff_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coeff_seq_ctrl_pkg
// Description : Shared definitions for the coefficient sequencer of the
//               nonlinear approximation engine: start marker, FSM state
//               encoding and default word/address widths.
// Revision    : 1.0 - initial release
// ============================================================================
package coeff_seq_ctrl_pkg;

  // Signalling NaN that ends the coefficient stream; never written to the FIFO.
  localparam logic [31:0] NAN_MARKER = 32'h7F90_0000;

  localparam int DEF_RAM_WIDTH  = 32;
  localparam int DEF_ADDR_LINES = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_EVAL   = 3'd3,
    ST_REWIND = 3'd4
  } state_t;

endpackage : coeff_seq_ctrl_pkg
`default_nettype wire

// File: rtl/coeff_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coeff_seq_ctrl
// Description : Coefficient FIFO sequencer. Streams host coefficients into
//               the FIFO until the NaN start marker, then for every accepted
//               sample replays all stored coefficients in write order and
//               rewinds the FIFO read pointer with a one-cycle redo pulse.
// Ports       : clk_i/rst_i            clock, synchronous active-high reset
//               cfg_valid_i/data_i/ready_o   host coefficient stream
//               fifo_wr_en_o/data_o/full_i   FIFO write side
//               fifo_rd_en_o/redo_o/data_i   FIFO read side (1-cycle latency)
//               x_valid_i/data_i/ready_o/x_o sample input and latched sample
//               coeff_valid_o/coeff_o/idx_o/last_o  coefficient stream out
//               busy_o, err_o (sticky)      status
// Revision    : 1.0 - initial release
// ============================================================================
module coeff_seq_ctrl
  import coeff_seq_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int ADDR_LINES = DEF_ADDR_LINES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  input  logic [RAM_WIDTH-1:0]  cfg_data_i,
  output logic                  cfg_ready_o,
  output logic                  fifo_wr_en_o,
  output logic [RAM_WIDTH-1:0]  fifo_data_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_rd_en_o,
  output logic                  fifo_redo_o,
  input  logic [RAM_WIDTH-1:0]  fifo_data_i,
  input  logic                  x_valid_i,
  input  logic [RAM_WIDTH-1:0]  x_data_i,
  output logic                  x_ready_o,
  output logic [RAM_WIDTH-1:0]  x_o,
  output logic                  coeff_valid_o,
  output logic [RAM_WIDTH-1:0]  coeff_o,
  output logic [ADDR_LINES-1:0] coeff_idx_o,
  output logic                  coeff_last_o,
  output logic                  busy_o,
  output logic                  err_o
);

  // cnt/idx carry one extra bit so a completely full FIFO (1<<ADDR_LINES) is representable.
  localparam logic [ADDR_LINES:0] C_MAX_COEFF = {1'b1, {ADDR_LINES{1'b0}}};
  localparam logic [ADDR_LINES:0] C_ONE       = {{ADDR_LINES{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_LINES:0]   r_cnt;
  logic [ADDR_LINES:0]   r_idx;
  logic [RAM_WIDTH-1:0]  r_x;
  logic                  r_err;
  logic                  r_vld;
  logic [ADDR_LINES-1:0] r_vld_idx;
  logic                  r_vld_last;

  logic w_is_marker;
  logic w_cnt_inc;
  logic w_err_set;
  logic w_x_latch;
  logic w_idx_clr;
  logic w_last_rd;

  assign w_is_marker = (cfg_data_i == RAM_WIDTH'(NAN_MARKER));

  always_comb begin
    w_next       = r_state;
    cfg_ready_o  = 1'b0;
    fifo_wr_en_o = 1'b0;
    fifo_rd_en_o = 1'b0;
    fifo_redo_o  = 1'b0;
    x_ready_o    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_err_set    = 1'b0;
    w_x_latch    = 1'b0;
    w_idx_clr    = 1'b0;
    w_last_rd    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          // cnt is always 0 here, so a marker means an empty coefficient set.
          if (w_is_marker) begin
            w_err_set = 1'b1;
          end else begin
            fifo_wr_en_o = 1'b1;
            w_cnt_inc    = 1'b1;
            w_next       = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        cfg_ready_o = ~fifo_full_i;
        if (cfg_valid_i && !fifo_full_i) begin
          if (w_is_marker) begin
            w_next = ST_READY;
          end else if (r_cnt == C_MAX_COEFF) begin
            w_err_set = 1'b1;
          end else begin
            fifo_wr_en_o = 1'b1;
            w_cnt_inc    = 1'b1;
          end
        end
      end
      ST_READY: begin
        x_ready_o = 1'b1;
        if (x_valid_i) begin
          w_x_latch = 1'b1;
          w_idx_clr = 1'b1;
          w_next    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        fifo_rd_en_o = 1'b1;
        if (r_idx == (r_cnt - C_ONE)) begin
          w_last_rd = 1'b1;
          w_next    = ST_REWIND;
        end
      end
      ST_REWIND: begin
        // Coincides with the last coefficient leaving the FIFO, so no gap is added.
        fifo_redo_o = 1'b1;
        w_next      = ST_READY;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_x        <= '0;
      r_err      <= 1'b0;
      r_vld      <= 1'b0;
      r_vld_idx  <= '0;
      r_vld_last <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_cnt_inc) r_cnt <= r_cnt + C_ONE;
      if (w_idx_clr) r_idx <= '0;
      else if (fifo_rd_en_o) r_idx <= r_idx + C_ONE;
      if (w_x_latch) r_x <= x_data_i;
      if (w_err_set) r_err <= 1'b1;
      // FIFO read data arrives one cycle after the read; tag it to match.
      r_vld      <= fifo_rd_en_o;
      r_vld_idx  <= r_idx[ADDR_LINES-1:0];
      r_vld_last <= w_last_rd;
    end
  end

  assign fifo_data_o   = cfg_data_i;
  assign x_o           = r_x;
  assign coeff_valid_o = r_vld;
  assign coeff_o       = fifo_data_i;
  assign coeff_idx_o   = r_vld_idx;
  assign coeff_last_o  = r_vld & r_vld_last;
  assign busy_o        = (r_state == ST_LOAD) || (r_state == ST_EVAL) || (r_state == ST_REWIND);
  assign err_o         = r_err;

endmodule : coeff_seq_ctrl
`default_nettype wire

// File: tb/tb_coeff_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_coeff_seq_ctrl
// Description : Self-checking bench for coeff_seq_ctrl with a behavioural
//               FIFO and an expected-coefficient list per load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coeff_seq_ctrl;

  localparam int AL = 3;
  localparam int MAXC = 1 << AL;
  localparam logic [31:0] NAN = 32'h7F90_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic [31:0] cfg_data = '0;
  logic cfg_ready;
  logic fifo_wr_en;
  logic [31:0] fifo_wdata;
  logic fifo_full = 1'b0;
  logic fifo_rd_en;
  logic fifo_redo;
  logic [31:0] fifo_rdata = '0;
  logic x_valid = 1'b0;
  logic [31:0] x_data = '0;
  logic x_ready;
  logic [31:0] x_out;
  logic coeff_valid;
  logic [31:0] coeff;
  logic [AL-1:0] coeff_idx;
  logic coeff_last;
  logic busy;
  logic err;

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coeff_seq_ctrl #(.RAM_WIDTH(32), .ADDR_LINES(AL)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready),
    .fifo_wr_en_o(fifo_wr_en), .fifo_data_o(fifo_wdata), .fifo_full_i(fifo_full),
    .fifo_rd_en_o(fifo_rd_en), .fifo_redo_o(fifo_redo), .fifo_data_i(fifo_rdata),
    .x_valid_i(x_valid), .x_data_i(x_data), .x_ready_o(x_ready), .x_o(x_out),
    .coeff_valid_o(coeff_valid), .coeff_o(coeff), .coeff_idx_o(coeff_idx),
    .coeff_last_o(coeff_last), .busy_o(busy), .err_o(err)
  );

  // Behavioural FIFO: write log, 1-cycle read latency, redo rewinds the read pointer.
  logic [31:0] mem [0:15];
  int wptr = 0;
  int rptr = 0;
  logic [31:0] wr_log [$];

  always @(posedge clk) begin
    if (rst) begin
      wptr <= 0;
      rptr <= 0;
      wr_log.delete();
    end else begin
      if (fifo_wr_en) begin
        mem[wptr % 16] <= fifo_wdata;
        wptr <= wptr + 1;
        wr_log.push_back(fifo_wdata);
      end
      if (fifo_redo) rptr <= 0;
      else if (fifo_rd_en) begin
        fifo_rdata <= mem[rptr % 16];
        rptr <= rptr + 1;
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == NAN);
    return w;
  endfunction

  // All tasks start and end just after a rising edge.
  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; x_valid = 1'b0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_cfg(input logic [31:0] w);
    int t = 0;
    cfg_valid = 1'b1; cfg_data = w;
    @(negedge clk);
    while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
    if (!cfg_ready) begin
      vectors++; errors++;
      $display("FAIL cfg_timeout: cfg_ready=%b required 1", cfg_ready);
    end
    @(posedge clk); #1 cfg_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] words [$]);
    foreach (words[i]) send_cfg(words[i]);
    send_cfg(NAN);
    vectors++;
    if (wr_log.size() != words.size()) begin
      errors++;
      $display("FAIL load_count: writes=%0d required %0d", wr_log.size(), words.size());
    end else begin
      foreach (words[i]) if (wr_log[i] !== words[i]) begin
        errors++;
        $display("FAIL load_data[%0d]: got %h required %h", i, wr_log[i], words[i]);
      end
    end
  endtask

  // One sample replay starting at handshake cycle T; returns at start of T+N+2.
  task automatic replay(input logic [31:0] x, input bit hold, input logic [31:0] exp_q [$]);
    int n = exp_q.size();
    logic e_rd, e_cv, e_redo, e_last;
    logic [AL-1:0] e_idx;
    x_valid = 1'b1; x_data = x;
    @(negedge clk);
    vectors++;
    if (x_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL replay_accept: x_ready=%b busy=%b required 1/0", x_ready, busy);
    end
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1 && !hold) x_valid = 1'b0;
      @(negedge clk);
      e_rd = (k <= n); e_cv = (k >= 2); e_redo = (k == n + 1);
      vectors++;
      if (fifo_rd_en !== e_rd || coeff_valid !== e_cv || fifo_redo !== e_redo ||
          x_ready !== 1'b0 || busy !== 1'b1 || x_out !== x) begin
        errors++;
        $display("FAIL replay_strobes T+%0d: rd=%b cv=%b redo=%b xr=%b busy=%b x=%h required %b %b %b 0 1 %h",
                 k, fifo_rd_en, coeff_valid, fifo_redo, x_ready, busy, x_out, e_rd, e_cv, e_redo, x);
      end
      if (e_cv) begin
        e_idx = AL'(k - 2);
        e_last = (k - 2 == n - 1);
        vectors++;
        if (coeff !== exp_q[k-2] || coeff_idx !== e_idx || coeff_last !== e_last) begin
          errors++;
          $display("FAIL replay_coeff T+%0d: coeff=%h idx=%0d last=%b required %h %0d %b",
                   k, coeff, coeff_idx, coeff_last, exp_q[k-2], e_idx, e_last);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if (cfg_ready !== 1'b1 || x_ready !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_rd_en !== 1'b0 ||
        fifo_redo !== 1'b0 || coeff_valid !== 1'b0 || coeff_last !== 1'b0 || busy !== 1'b0 ||
        err !== 1'b0 || x_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: cr=%b xr=%b wr=%b rd=%b redo=%b cv=%b last=%b busy=%b err=%b x=%h",
               cfg_ready, x_ready, fifo_wr_en, fifo_rd_en, fifo_redo, coeff_valid, coeff_last, busy, err, x_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] q [$];
    q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    do_reset();
    load(q);
    // Config traffic while READY is ignored.
    cfg_valid = 1'b1; cfg_data = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if (cfg_ready !== 1'b0 || fifo_wr_en !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL ready_cfg_ignore: cr=%b wr=%b err=%b required 0 0 0", cfg_ready, fifo_wr_en, err);
    end
    @(posedge clk); #1 cfg_valid = 1'b0;
    replay(32'h3F00_0000, 1'b0, q);
    @(negedge clk);
    vectors++;
    if (x_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || wr_log.size() != 3) begin
      errors++;
      $display("FAIL basic_end: xr=%b busy=%b err=%b writes=%0d required 1 0 0 3", x_ready, busy, err, wr_log.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_marker_first();
    do_reset();
    send_cfg(NAN);
    @(negedge clk);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1 || x_ready !== 1'b0 || wr_log.size() != 0) begin
      errors++;
      $display("FAIL marker_first: err=%b busy=%b cr=%b xr=%b writes=%0d required 1 0 1 0 0",
               err, busy, cfg_ready, x_ready, wr_log.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    repeat (3) q.push_back(rand_word());
    do_reset();
    load(q);
    replay(rand_word(), 1'b1, q);
    replay(rand_word(), 1'b0, q);
    @(negedge clk);
    vectors++;
    if (x_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: x_ready=%b required 1", x_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fifo_full();
    logic [31:0] q [$];
    q = '{rand_word(), rand_word()};
    do_reset();
    send_cfg(q[0]);
    fifo_full = 1'b1; cfg_valid = 1'b1; cfg_data = q[1];
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (cfg_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL full_stall: cr=%b wr=%b required 0 0", cfg_ready, fifo_wr_en);
      end
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    @(negedge clk);
    vectors++;
    if (cfg_ready !== 1'b1 || fifo_wr_en !== 1'b1 || fifo_wdata !== q[1]) begin
      errors++;
      $display("FAIL full_release: cr=%b wr=%b data=%h required 1 1 %h", cfg_ready, fifo_wr_en, fifo_wdata, q[1]);
    end
    @(posedge clk); #1 cfg_valid = 1'b0;
    send_cfg(NAN);
    vectors++;
    if (wr_log.size() != 2) begin
      errors++;
      $display("FAIL full_writes: writes=%0d required 2", wr_log.size());
    end
    replay(rand_word(), 1'b0, q);
  endtask

  task automatic test_overflow();
    logic [31:0] q [$];
    logic [31:0] extra;
    do_reset();
    for (int i = 0; i < MAXC; i++) begin
      q.push_back(rand_word());
      send_cfg(q[i]);
    end
    extra = rand_word();
    cfg_valid = 1'b1; cfg_data = extra;
    @(negedge clk);
    vectors++;
    if (cfg_ready !== 1'b1 || fifo_wr_en !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drop: cr=%b wr=%b err=%b required 1 0 0", cfg_ready, fifo_wr_en, err);
    end
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: err=%b required 1", err);
    end
    @(posedge clk); #1;
    send_cfg(NAN);
    vectors++;
    if (wr_log.size() != MAXC) begin
      errors++;
      $display("FAIL overflow_writes: writes=%0d required %0d", wr_log.size(), MAXC);
    end
    replay(rand_word(), 1'b0, q);
  endtask

  task automatic test_reset_mid();
    logic [31:0] q [$];
    repeat (3) q.push_back(rand_word());
    do_reset();
    send_cfg(NAN);           // sets the sticky error first
    load(q);
    x_valid = 1'b1; x_data = rand_word();    // handshake in cycle T
    @(posedge clk); #1 x_valid = 1'b0;       // T+1
    @(posedge clk); #1;                      // T+2
    @(posedge clk); #1 rst = 1'b1;           // T+3
    @(posedge clk); #1 rst = 1'b0;           // T+4
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (fifo_rd_en !== 1'b0 || coeff_valid !== 1'b0 || fifo_redo !== 1'b0 || coeff_last !== 1'b0 ||
          cfg_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || x_ready !== 1'b0 || x_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_mid: rd=%b cv=%b redo=%b last=%b cr=%b busy=%b err=%b xr=%b x=%h",
                 fifo_rd_en, coeff_valid, fifo_redo, coeff_last, cfg_ready, busy, err, x_ready, x_out);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [31:0] q [$];
      int n = $urandom_range(1, MAXC);
      int ns = $urandom_range(1, 3);
      bit hold;
      for (int i = 0; i < n; i++) q.push_back(rand_word());
      do_reset();
      load(q);
      for (int s = 0; s < ns; s++) begin
        hold = (s < ns - 1) && ($urandom_range(0, 1) == 1);
        replay(rand_word(), hold, q);
        if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      x_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (x_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL random_end[%0d]: xr=%b busy=%b err=%b required 1 0 0", r, x_ready, busy, err);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_marker_first();
    test_back_to_back();
    test_fifo_full();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_coeff_seq_ctrl
`default_nettype wire
